// File: rtl/octa16_pkg.sv
// Shared register-file constants for the octa16 core: address width, entry count, hardwired zero register.
package octa16_pkg;
    localparam int                  REG_ADDR_W = 3;
    localparam int                  NUM_REGS   = 8;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 3'd0;
endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first valid at or above ptr, wrapping, wins.
// Latency: combinational.
// Backpressure: none; grant is zero when no input is valid.
module rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = 1
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   idx
);

    logic [PTR_W-1:0] j;
    logic             found;

    always_comb begin
        grant = '0;
        idx   = '0;
        j     = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = PTR_W'((int'(ptr) + k) % NUM_REQ);
            if (valid[j] && !found) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = j;
            end
        end
    end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Round-robin arbiter for the register-file write port plus RAW scoreboard; REG_WB_BYPASS_EN adds forwarding.
// Latency: 1 cycle from req_valid&&req_ready to wr_en; stall is combinational.
// Backpressure: one grant per cycle, the write port never stalls, losers wait with req_ready low.
module reg_wb_arbiter
    import octa16_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [REG_ADDR_W*NUM_REQ-1:0] req_rd,
    input  logic [DATA_WIDTH*NUM_REQ-1:0] req_data,
    output logic                          wr_en,
    output logic [REG_ADDR_W-1:0]         wr_rd,
    output logic [DATA_WIDTH-1:0]         wr_data,
    input  logic                          sb_set,
    input  logic [REG_ADDR_W-1:0]         sb_rd,
    input  logic [REG_ADDR_W-1:0]         rs1,
    input  logic [REG_ADDR_W-1:0]         rs2,
`ifdef REG_WB_BYPASS_EN
    output logic                          fwd1,
    output logic                          fwd2,
    output logic [DATA_WIDTH-1:0]         fwd_data,
`endif
    output logic                          stall,
    output logic [NUM_REGS-1:0]           busy
);

    localparam int PTR_W = (NUM_REQ > 2) ? 2 : 1;

    logic [PTR_W-1:0]      ptr;
    logic [PTR_W-1:0]      idx;
    logic [PTR_W-1:0]      ptr_nxt;
    logic [NUM_REQ-1:0]    grant;
    logic [REG_ADDR_W-1:0] sel_rd;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [NUM_REGS-1:0]   busy_nxt;
    logic                  hz1;
    logic                  hz2;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .valid (req_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (idx)
    );

    assign req_ready = grant;
    assign ptr_nxt   = PTR_W'((int'(idx) + 1) % NUM_REQ);

    always_comb begin
        sel_rd   = REG_ZERO;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_rd   = req_rd[REG_ADDR_W*i +: REG_ADDR_W];
                sel_data = req_data[DATA_WIDTH*i +: DATA_WIDTH];
            end
        end
    end

    // Set is applied after clear so a newer outstanding write keeps the bit.
    always_comb begin
        busy_nxt = busy;
        if (wr_en && wr_rd != REG_ZERO)
            busy_nxt[wr_rd] = 1'b0;
        if (sb_set && sb_rd != REG_ZERO)
            busy_nxt[sb_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en   <= 1'b0;
            wr_rd   <= REG_ZERO;
            wr_data <= '0;
            ptr     <= '0;
            busy    <= '0;
        end else begin
            if (|grant) begin
                wr_en   <= (sel_rd != REG_ZERO);
                wr_rd   <= sel_rd;
                wr_data <= sel_data;
                ptr     <= ptr_nxt;
            end else begin
                wr_en   <= 1'b0;
            end
            busy <= busy_nxt;
        end
    end

    assign hz1 = (rs1 != REG_ZERO) && busy[rs1];
    assign hz2 = (rs2 != REG_ZERO) && busy[rs2];

`ifdef REG_WB_BYPASS_EN
    assign fwd1     = (rs1 != REG_ZERO) && wr_en && (wr_rd == rs1);
    assign fwd2     = (rs2 != REG_ZERO) && wr_en && (wr_rd == rs2);
    assign fwd_data = wr_data;
    assign stall    = (hz1 && !fwd1) || (hz2 && !fwd2);
`else
    assign stall    = hz1 || hz2;
`endif

endmodule
